// File: rtl/tl45_writeback_if.sv
// Result/writeback bundle between the execute/memory units, the writeback arbiter and the register file.
// Forwarding signals exist only when TL45_WB_FORWARD_EN is defined.
interface tl45_writeback_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [31:0] mem_data;
    logic        stall;
    logic        wb_wr;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [3:0]  wb_clear;
    logic [15:0] commit_count;
`ifdef TL45_WB_FORWARD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_reg;
    logic [31:0] fwd_data;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, stall,
        input  alu_ready, mem_ready, wb_wr, wb_reg, wb_data, wb_clear, commit_count,
        input  fwd_valid, fwd_reg, fwd_data
    );
    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, stall,
        output alu_ready, mem_ready, wb_wr, wb_reg, wb_data, wb_clear, commit_count,
        output fwd_valid, fwd_reg, fwd_data
    );
`else
    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, stall,
        input  alu_ready, mem_ready, wb_wr, wb_reg, wb_data, wb_clear, commit_count
    );
    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, stall,
        output alu_ready, mem_ready, wb_wr, wb_reg, wb_data, wb_clear, commit_count
    );
`endif
endinterface

// File: rtl/tl45_writeback.sv
// TL45 writeback arbiter: one-entry buffer per source, round-robin grant, one register write per cycle.
// Optional combinational forwarding of the granted entry when TL45_WB_FORWARD_EN is defined.
module tl45_writeback (
    input  logic             clk,
    input  logic             reset,
    tl45_writeback_if.slave  bus
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_t;

    src_t        rr;
    src_t        rr_next;
    logic        alu_full;
    logic [3:0]  alu_reg_q;
    logic [31:0] alu_data_q;
    logic        mem_full;
    logic [3:0]  mem_reg_q;
    logic [31:0] mem_data_q;
    logic        grant_alu;
    logic        grant_mem;
    logic        grant;
    logic [3:0]  sel_reg;
    logic [31:0] sel_data;
    logic        sel_writes;
    logic        wb_wr_q;
    logic [3:0]  wb_reg_q;
    logic [31:0] wb_data_q;
    logic [3:0]  wb_clear_q;
    logic [15:0] count_q;
    logic        alu_take;
    logic        mem_take;

    // Grants depend only on slot occupancy, rr and stall so ready never loops back through valid.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        rr_next   = rr;
        if (!bus.stall) begin
            if (alu_full && mem_full) begin
                grant_alu = (rr == SRC_ALU);
                grant_mem = (rr == SRC_MEM);
            end else begin
                grant_alu = alu_full;
                grant_mem = mem_full;
            end
            if (grant_alu) begin
                rr_next = SRC_MEM;
            end else if (grant_mem) begin
                rr_next = SRC_ALU;
            end
        end
    end

    assign grant      = grant_alu | grant_mem;
    assign sel_reg    = grant_mem ? mem_reg_q  : alu_reg_q;
    assign sel_data   = grant_mem ? mem_data_q : alu_data_q;
    assign sel_writes = grant && (sel_reg != 4'd0);

    assign bus.alu_ready = !alu_full || grant_alu;
    assign bus.mem_ready = !mem_full || grant_mem;
    assign alu_take      = bus.alu_valid && bus.alu_ready;
    assign mem_take      = bus.mem_valid && bus.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= SRC_ALU;
        end else begin
            rr <= rr_next;
        end
    end

    // A slot may drain and refill on the same edge, so the load wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_full   <= 1'b0;
            alu_reg_q  <= 4'd0;
            alu_data_q <= 32'd0;
        end else if (alu_take) begin
            alu_full   <= 1'b1;
            alu_reg_q  <= bus.alu_reg;
            alu_data_q <= bus.alu_data;
        end else if (grant_alu) begin
            alu_full   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_full   <= 1'b0;
            mem_reg_q  <= 4'd0;
            mem_data_q <= 32'd0;
        end else if (mem_take) begin
            mem_full   <= 1'b1;
            mem_reg_q  <= bus.mem_reg;
            mem_data_q <= bus.mem_data;
        end else if (grant_mem) begin
            mem_full   <= 1'b0;
        end
    end

    // Reg-0 entries still update the address/data holding registers but never write or clear busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_wr_q    <= 1'b0;
            wb_reg_q   <= 4'd0;
            wb_data_q  <= 32'd0;
            wb_clear_q <= 4'd0;
        end else if (grant) begin
            wb_wr_q    <= sel_writes;
            wb_reg_q   <= sel_reg;
            wb_data_q  <= sel_data;
            wb_clear_q <= sel_writes ? sel_reg : 4'd0;
        end else begin
            wb_wr_q    <= 1'b0;
            wb_clear_q <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 16'd0;
        end else if (wb_wr_q) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.wb_wr        = wb_wr_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_clear     = wb_clear_q;
    assign bus.commit_count = count_q;

`ifdef TL45_WB_FORWARD_EN
    assign bus.fwd_valid = sel_writes;
    assign bus.fwd_reg   = sel_reg;
    assign bus.fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_tl45_writeback.sv
// Self-checking bench for tl45_writeback: directed test-plan steps plus a random phase,
// all checked against a queue-based model of the writeback rules.
module tb_tl45_writeback;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic reset;
    tl45_writeback_if bus();

    tl45_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_count = 0;
    int check_count = 0;

    // Model state: each source buffer is a queue holding at most one result.
    ent_t        alu_q[$];
    ent_t        mem_q[$];
    int          m_rr;
    logic        m_wb_wr;
    logic [3:0]  m_wb_reg;
    logic [31:0] m_wb_data;
    logic [3:0]  m_wb_clear;
    logic [15:0] m_count;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic model_reset();
        alu_q.delete();
        mem_q.delete();
        m_rr       = 0;
        m_wb_wr    = 1'b0;
        m_wb_reg   = 4'd0;
        m_wb_data  = 32'd0;
        m_wb_clear = 4'd0;
        m_count    = 16'd0;
    endtask

    // Called just after a rising edge: drive one cycle of inputs, check readies, cross the edge, check outputs.
    task automatic apply_stimulus(input bit av, input logic [3:0] ar, input logic [31:0] ad,
                                  input bit mv, input logic [3:0] mr, input logic [31:0] md,
                                  input bit st);
        bit   a_full, m_full, ga, gm, exp_ar, exp_mr;
        ent_t e;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_reg   = mr;
        bus.mem_data  = md;
        bus.stall     = st;
        #1;
        a_full = (alu_q.size() != 0);
        m_full = (mem_q.size() != 0);
        ga = !st && a_full && (!m_full || m_rr == 0);
        gm = !st && m_full && (!a_full || m_rr == 1);
        exp_ar = !a_full || ga;
        exp_mr = !m_full || gm;
        check_output("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
        check_output("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
        @(posedge clk);
        m_count = m_count + 16'(m_wb_wr);
        if (ga || gm) begin
            e = ga ? alu_q.pop_front() : mem_q.pop_front();
            m_wb_reg   = e.r;
            m_wb_data  = e.d;
            m_wb_wr    = (e.r != 4'd0);
            m_wb_clear = m_wb_wr ? e.r : 4'd0;
            m_rr       = ga ? 1 : 0;
        end else begin
            m_wb_wr    = 1'b0;
            m_wb_clear = 4'd0;
        end
        if (av && exp_ar) alu_q.push_back('{r: ar, d: ad});
        if (mv && exp_mr) mem_q.push_back('{r: mr, d: md});
        #1;
        check_output("wb_wr",        32'(bus.wb_wr),        32'(m_wb_wr));
        check_output("wb_reg",       32'(bus.wb_reg),       32'(m_wb_reg));
        check_output("wb_data",      bus.wb_data,           m_wb_data);
        check_output("wb_clear",     32'(bus.wb_clear),     32'(m_wb_clear));
        check_output("commit_count", 32'(bus.commit_count), 32'(m_count));
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) apply_stimulus(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, st);
    endtask

    initial begin
        reset = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = 4'd0;
        bus.alu_data  = 32'd0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = 4'd0;
        bus.mem_data  = 32'd0;
        bus.stall     = 1'b0;
        model_reset();
        #12;
        check_output("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check_output("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        check_output("rst_wb_wr",     32'(bus.wb_wr),     32'd0);
        check_output("rst_wb_reg",    32'(bus.wb_reg),    32'd0);
        check_output("rst_wb_data",   bus.wb_data,        32'd0);
        check_output("rst_wb_clear",  32'(bus.wb_clear),  32'd0);
        check_output("rst_count",     32'(bus.commit_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single ALU write");
        apply_stimulus(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0, 0);
        idle(1, 0);
        check_output("first_wb_wr",    32'(bus.wb_wr),    32'd1);
        check_output("first_wb_reg",   32'(bus.wb_reg),   32'd3);
        check_output("first_wb_data",  bus.wb_data,       32'hDEADBEEF);
        check_output("first_wb_clear", 32'(bus.wb_clear), 32'd3);
        idle(1, 0);
        check_output("first_count",    32'(bus.commit_count), 32'd1);

        $display("[TB] contention");
        for (int i = 0; i < 6; i++)
            apply_stimulus(1, 4'(1 + i), 32'h1000 + i, 1, 4'(9 + i), 32'h2000 + i, 0);
        idle(3, 0);

        $display("[TB] ALU streaming");
        for (int i = 1; i <= 8; i++)
            apply_stimulus(1, 4'(i), 32'hA000 + i, 0, 4'd0, 32'd0, 0);
        idle(2, 0);

        $display("[TB] reg 0 drop");
        apply_stimulus(1, 4'd0, 32'h1234, 0, 4'd0, 32'd0, 0);
        idle(3, 0);

        $display("[TB] async reset mid-stream");
        apply_stimulus(1, 4'd5, 32'hA5A50005, 0, 4'd0, 32'd0, 0);
        apply_stimulus(1, 4'd6, 32'hA5A50006, 1, 4'd7, 32'hA5A50007, 0);
        reset = 1'b1;
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        check_output("mid_rst_wb_wr",    32'(bus.wb_wr),        32'd0);
        check_output("mid_rst_wb_clear", 32'(bus.wb_clear),     32'd0);
        check_output("mid_rst_wb_reg",   32'(bus.wb_reg),       32'd0);
        check_output("mid_rst_count",    32'(bus.commit_count), 32'd0);
        check_output("mid_rst_alu_rdy",  32'(bus.alu_ready),    32'd1);
        check_output("mid_rst_mem_rdy",  32'(bus.mem_ready),    32'd1);
        model_reset();
        #1;
        reset = 1'b0;
        idle(3, 0);

        $display("[TB] stall with both slots full");
        apply_stimulus(1, 4'd9, 32'h0000_0909, 1, 4'd10, 32'h0000_0A0A, 1);
        idle(3, 1);
        check_output("stall_alu_rdy", 32'(bus.alu_ready), 32'd0);
        check_output("stall_mem_rdy", 32'(bus.mem_ready), 32'd0);
        idle(1, 0);
        check_output("release_first", 32'(bus.wb_reg), 32'd9);
        idle(1, 0);
        check_output("release_second", 32'(bus.wb_reg), 32'd10);
        idle(2, 0);

        $display("[TB] random phase");
        for (int i = 0; i < 300; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                           1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                           ($urandom_range(0, 4) == 0));
        idle(4, 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
